// File: rtl/dmem_responder.sv
// dmem_responder: load/store target for the core's data port with programmable wait states,
// RISC-V byte/half/word access semantics and error flagging.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_acc_mode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  if (WAIT_CYCLES > 15 || WAIT_CYCLES < 0) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end
  state_t      r_state, w_next;
  logic        r_we, r_err;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [2:0]  r_mode;
  logic [3:0]  r_cnt;
  logic [31:0] r_mem [DEPTH_WORDS] = '{default: '0};
  logic          w_access, w_err, w_write;
  logic [AW-1:0] w_idx;
  logic [7:0]    w_b;
  logic [15:0]   w_h;
  logic [31:0]   w_rd, w_load, w_mask, w_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (req_valid ? WAIT : IDLE) :
             r_state == WAIT ? (r_cnt == 4'd0 ? RESP : WAIT) :
             (rsp_ready ? IDLE : RESP);
  always_comb begin
    req_ready = r_state == IDLE;
    rsp_valid = r_state == RESP;
    rsp_rdata = r_rdata;
    rsp_err   = r_err;
  end
  // access happens on the edge that leaves WAIT, using the latched request
  always_comb begin
    w_access = r_state == WAIT && r_cnt == 4'd0;
    w_idx    = r_addr[AW+1:2];
    w_rd     = r_mem[w_idx];
    w_err    = r_mode == 3'b011 || r_mode[2:1] == 2'b11 || (r_we && r_mode[2]) ||
               (r_mode[1:0] == 2'b01 && r_addr[0]) ||
               (r_mode[1:0] == 2'b10 && r_addr[1:0] != 2'b00) ||
               {2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS);
    w_b      = 8'(w_rd >> {r_addr[1:0], 3'b000});
    w_h      = 16'(w_rd >> {r_addr[1], 4'b0000});
    w_load   = r_mode[1:0] == 2'b00 ? {{24{w_b[7] & ~r_mode[2]}}, w_b} :
               r_mode[1:0] == 2'b01 ? {{16{w_h[15] & ~r_mode[2]}}, w_h} : w_rd;
    w_mask   = r_mode[1:0] == 2'b00 ? 32'h0000_00FF << {r_addr[1:0], 3'b000} :
               r_mode[1:0] == 2'b01 ? 32'h0000_FFFF << {r_addr[1], 4'b0000} : '1;
    w_data   = r_mode[1:0] == 2'b00 ? {4{r_wdata[7:0]}} :
               r_mode[1:0] == 2'b01 ? {2{r_wdata[15:0]}} : r_wdata;
    w_write  = w_access && r_we && !w_err;
  end
  always_ff @(posedge clk)
    if (w_write) r_mem[w_idx] <= (w_rd & ~w_mask) | (w_data & w_mask);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mode  <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_mode  <= req_acc_mode;
        r_cnt   <= 4'(WAIT_CYCLES);
      end else if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_access) begin
        r_rdata <= (r_we || w_err) ? 32'd0 : w_load;
        r_err   <= w_err;
      end else if (rsp_valid && rsp_ready) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against a byte-array model.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int WAITC = 2;
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [2:0] req_acc_mode = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int total = 0, bad = 0;
  logic [7:0] ref_b [4*DEPTH];
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_acc_mode(req_acc_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));
  // Memory as bytes; access width, legality and extension derived straight from the access rules.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] mode, output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] v;
    n = mode[1:0] == 2'd0 ? 1 : mode[1:0] == 2'd1 ? 2 : 4;
    er = mode == 3'b011 || mode == 3'b110 || mode == 3'b111 || (we && mode[2]) ||
         (addr % n) != 0 || addr >= 32'(4*DEPTH);
    rd = 0;
    if (!er) begin
      if (we) for (int i = 0; i < n; i++) ref_b[int'(addr) + i] = wdata[8*i +: 8];
      else begin
        v = 0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[int'(addr) + i];
        if (!mode[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 1);
        rd = v;
      end
    end
  endtask
  task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] mode, output logic [31:0] rd, output logic er,
                     output int lat, output logic [31:0] exp_rd, output logic exp_er);
    model(we, addr, wdata, mode, exp_rd, exp_er);
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_acc_mode = mode;
    @(posedge clk); #1;
    req_valid = 0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_acc_mode = 3'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    total++;
    if (!rsp_valid) begin bad++; $display("FAIL rsp_timeout addr=%h", addr); end
    @(negedge clk);
    rd = rsp_rdata; er = rsp_err; rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL rsp_release got valid=%b ready=%b rdata=%h err=%b want 0 1 0 0",
               rsp_valid, req_ready, rsp_rdata, rsp_err);
    end
  endtask
  task automatic test_reset;
    #3;
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got valid=%b rdata=%h err=%b want 0", rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (3) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_ready got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
  endtask
  task automatic test_word;
    logic [31:0] rd, xr; logic er, xe; int lat;
    run(1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lat, xr, xe);
    total++; if (er !== 1'b0 || rd !== 32'd0) begin bad++; $display("FAIL store_w got err=%b rdata=%h want 0 0", er, rd); end
    run(0, 32'h10, 0, 3'b010, rd, er, lat, xr, xe);
    total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL load_w got %h/%b want deadbeef/0", rd, er); end
    total++; if (lat != WAITC + 1) begin bad++; $display("FAIL latency got %0d want %0d", lat, WAITC + 1); end
  endtask
  task automatic test_byte_half;
    logic [31:0] rd, xr; logic er, xe; int lat;
    run(1, 32'h11, 32'h000000A5, 3'b000, rd, er, lat, xr, xe);
    run(0, 32'h11, 0, 3'b000, rd, er, lat, xr, xe);
    total++; if (rd !== 32'hFFFFFFA5) begin bad++; $display("FAIL load_b got %h want ffffffa5", rd); end
    run(0, 32'h11, 0, 3'b100, rd, er, lat, xr, xe);
    total++; if (rd !== 32'h000000A5) begin bad++; $display("FAIL load_bu got %h want 000000a5", rd); end
    run(0, 32'h10, 0, 3'b010, rd, er, lat, xr, xe);
    total++; if (rd !== 32'hDEADA5EF) begin bad++; $display("FAIL load_w_merge got %h want deada5ef", rd); end
    run(1, 32'h12, 32'h00008001, 3'b001, rd, er, lat, xr, xe);
    run(0, 32'h12, 0, 3'b001, rd, er, lat, xr, xe);
    total++; if (rd !== 32'hFFFF8001) begin bad++; $display("FAIL load_h got %h want ffff8001", rd); end
    run(0, 32'h12, 0, 3'b101, rd, er, lat, xr, xe);
    total++; if (rd !== 32'h00008001) begin bad++; $display("FAIL load_hu got %h want 00008001", rd); end
    run(0, 32'h13, 0, 3'b001, rd, er, lat, xr, xe);
    total++; if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL load_h_misal got %b/%h want 1/0", er, rd); end
  endtask
  task automatic test_errors;
    logic [31:0] rd, xr; logic er, xe; int lat;
    run(1, 32'h12, 32'h11111111, 3'b010, rd, er, lat, xr, xe);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL store_w_misal got err=%b want 1", er); end
    run(1, 32'h10, 32'h22222222, 3'b101, rd, er, lat, xr, xe);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL store_hu got err=%b want 1", er); end
    run(0, 32'h10, 0, 3'b010, rd, er, lat, xr, xe);
    total++; if (rd !== 32'h8001A5EF || er !== 1'b0) begin bad++; $display("FAIL err_nowrite got %h/%b want 8001a5ef/0", rd, er); end
    run(0, 32'(4*DEPTH), 0, 3'b010, rd, er, lat, xr, xe);
    total++; if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL load_oor got %b/%h want 1/0", er, rd); end
    run(0, 32'h10, 0, 3'b011, rd, er, lat, xr, xe);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL mode_011 got err=%b want 1", er); end
    run(0, 32'(4*DEPTH - 4), 0, 3'b010, rd, er, lat, xr, xe);
    total++; if (er !== 1'b0 || rd !== 32'd0) begin bad++; $display("FAIL load_top got %b/%h want 0/0", er, rd); end
  endtask
  task automatic test_backpressure;
    logic [31:0] xr, held, rd, x2; logic xe, er, x2e; int n, lat;
    model(0, 32'h10, 0, 3'b010, xr, xe);
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 32'h10; req_acc_mode = 3'b010;
    @(posedge clk); #1;
    req_valid = 0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (!rsp_valid) begin bad++; $display("FAIL bp_timeout"); end
    held = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin req_valid = 1; req_we = 1; req_addr = 32'h10; req_wdata = 32'h55555555; end
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== xr || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got valid=%b rdata=%h ready=%b want 1 %h 0", i, rsp_valid, rsp_rdata, req_ready, xr);
      end
      @(posedge clk); #1; req_valid = 0;
    end
    total++; if (held !== xr) begin bad++; $display("FAIL bp_first got %h want %h", held, xr); end
    @(negedge clk); rsp_ready = 1;
    @(posedge clk); #1; rsp_ready = 0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
    run(0, 32'h10, 0, 3'b010, rd, er, lat, x2, x2e);
    total++; if (rd !== xr) begin bad++; $display("FAIL bp_ignored_store got %h want %h", rd, xr); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] rd, xr; logic er, xe; int lat;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'h12345678; req_acc_mode = 3'b010;
    @(posedge clk); #1; req_valid = 0;
    @(posedge clk); #2; rst = 0; #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL midreset_out got valid=%b rdata=%h err=%b want 0", rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1;
    run(0, 32'h20, 0, 3'b010, rd, er, lat, xr, xe);
    total++; if (rd !== xr || er !== 1'b0) begin bad++; $display("FAIL midreset_nowrite got %h want %h", rd, xr); end
  endtask
  task automatic test_random;
    logic [31:0] rd, xr, a; logic er, xe, we; int lat;
    logic [2:0] m;
    for (int k = 0; k < 120; k++) begin
      we = 1'($urandom);
      m = $urandom_range(0, 9) < 8 ? 3'($urandom) : 3'b010;
      a = $urandom_range(0, 15) == 0 ? 32'(4*DEPTH) + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 63));
      run(we, a, $urandom, m, rd, er, lat, xr, xe);
      total++;
      if (rd !== xr || er !== xe || lat != WAITC + 1) begin
        bad++;
        $display("FAIL rand k=%0d we=%b a=%h m=%b got %h/%b/%0d want %h/%b/%0d", k, we, a, m, rd, er, lat, xr, xe, WAITC + 1);
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 4*DEPTH; i++) ref_b[i] = 8'h00;
    test_reset;
    test_word;
    test_byte_half;
    test_errors;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
